// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-through, write-allocate data cache.
// Loads that hit return data combinationally in the same cycle. A miss
// stalls the pipeline while the FILL state streams a 16-byte line in as
// 8 pipelined word reads. Stores that hit update the cached word and are
// written through to main memory in the same cycle.
module dcache_ctrl #(
    parameter int INDEX_BITS = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr,
    input  logic [15:0] data_in,
    input  logic        rd,
    input  logic        wr,
    output logic [15:0] data_out,
    output logic        stall,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_data_out,
    output logic        mem_enable,
    output logic        mem_wr,
    input  logic [15:0] mem_data_in,
    input  logic        mem_data_valid,
    output logic [15:0] miss_cnt
);

    localparam int TAG_W = 12 - INDEX_BITS;
    localparam int LINES = 1 << INDEX_BITS;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_FILL = 1'b1
    } state_t;

    // FSM and fill bookkeeping
    state_t      state_q, state_d;
    logic [3:0]  issue_q, issue_d;     // requests issued so far, 0..8
    logic [2:0]  ret_q, ret_d;         // words returned so far, 0..7
    logic [11:0] base_line_q, base_line_d; // addr[15:4] of the line being filled
    logic [15:0] miss_cnt_q;
    logic        fill_done;

    // Storage: valid bits are reset, tag/data arrays are not
    logic [LINES-1:0] valid_q;
    logic [LINES-1:0] valid_set;
    logic [TAG_W-1:0] tag_mem  [LINES];
    logic [15:0]      data_mem [LINES*8];

    // Request decode
    logic [TAG_W-1:0]      req_tag;
    logic [INDEX_BITS-1:0] req_idx;
    logic [2:0]            req_off;
    logic [INDEX_BITS-1:0] fill_idx;
    logic                  req;
    logic                  hit;
    logic                  miss;
    logic [15:0]           line_word;

    // Byte-lane bit of the address has no meaning for a word cache
    logic unused_addr0;
    assign unused_addr0 = addr[0];

    assign req_tag   = addr[15:4+INDEX_BITS];
    assign req_idx   = addr[4+INDEX_BITS-1:4];
    assign req_off   = addr[3:1];
    assign fill_idx  = base_line_q[INDEX_BITS-1:0];
    assign req       = rd | wr;
    assign hit       = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
    assign miss      = (state_q == S_IDLE) && req && !hit;
    assign line_word = data_mem[{req_idx, req_off}];
    assign miss_cnt  = miss_cnt_q;

    // State register and fill counters
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            issue_q     <= 4'd0;
            ret_q       <= 3'd0;
            base_line_q <= 12'd0;
        end else begin
            state_q     <= state_d;
            issue_q     <= issue_d;
            ret_q       <= ret_d;
            base_line_q <= base_line_d;
        end
    end

    // Next-state logic: enter FILL on a miss, leave it on the 8th returned word
    always_comb begin
        state_d     = state_q;
        issue_d     = issue_q;
        ret_d       = ret_q;
        base_line_d = base_line_q;
        fill_done   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req && !hit) begin
                    state_d     = S_FILL;
                    issue_d     = 4'd0;
                    ret_d       = 3'd0;
                    base_line_d = addr[15:4];
                end
            end
            S_FILL: begin
                if (!issue_q[3]) begin
                    issue_d = issue_q + 4'd1;
                end
                if (mem_data_valid) begin
                    ret_d = ret_q + 3'd1;
                    if (ret_q == 3'd7) begin
                        fill_done = 1'b1;
                        state_d   = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic: hit data, write-through, fill requests and stall
    always_comb begin
        data_out     = 16'd0;
        stall        = 1'b0;
        mem_addr     = 16'd0;
        mem_data_out = 16'd0;
        mem_enable   = 1'b0;
        mem_wr       = 1'b0;
        if (!rst) begin
            case (state_q)
                S_IDLE: begin
                    if (req) begin
                        if (!hit) begin
                            stall = 1'b1;
                        end else if (wr) begin
                            mem_enable   = 1'b1;
                            mem_wr       = 1'b1;
                            mem_addr     = {addr[15:1], 1'b0};
                            mem_data_out = data_in;
                        end else begin
                            data_out = line_word;
                        end
                    end
                end
                S_FILL: begin
                    stall = 1'b1;
                    if (!issue_q[3]) begin
                        mem_enable = 1'b1;
                        mem_addr   = {base_line_q, issue_q[2:0], 1'b0};
                    end
                end
                default: ;
            endcase
        end
    end

    // Miss counter, wraps naturally at 16 bits
    always_ff @(posedge clk) begin
        if (rst) begin
            miss_cnt_q <= 16'd0;
        end else if (miss) begin
            miss_cnt_q <= miss_cnt_q + 16'd1;
        end
    end

    // One-hot decode of the line whose valid bit is set when a fill completes
    generate
        for (genvar gi = 0; gi < LINES; gi++) begin : g_valid_set
            assign valid_set[gi] = fill_done && (fill_idx == INDEX_BITS'(gi));
        end
    endgenerate

    // Valid bits: cleared by reset, set when a fill completes
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_q | valid_set;
        end
    end

    // Tag array: written once the whole line has arrived
    always_ff @(posedge clk) begin
        if (!rst && fill_done) begin
            tag_mem[fill_idx] <= base_line_q[11:INDEX_BITS];
        end
    end

    // Data array: store hits update one word, fills write returned words in order
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == S_IDLE && wr && hit) begin
                data_mem[{req_idx, req_off}] <= data_in;
            end else if (state_q == S_FILL && mem_data_valid) begin
                data_mem[{fill_idx, ret_q}] <= mem_data_in;
            end
        end
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Testbench for dcache_ctrl: directed transactions against a main-memory
// model with 4-cycle read latency. Memory word at byte address a starts
// out as a ^ 16'h5A5A; write-throughs update the model.
module tb_dcache_ctrl;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] addr;
    logic [15:0] data_in;
    logic        rd;
    logic        wr;
    logic [15:0] data_out;
    logic        stall;
    logic [15:0] mem_addr;
    logic [15:0] mem_data_out;
    logic        mem_enable;
    logic        mem_wr;
    logic [15:0] mem_data_in;
    logic        mem_data_valid;
    logic [15:0] miss_cnt;

    int total = 0;
    int bad   = 0;

    logic [15:0] mem [0:32767];
    logic        pipe_v [1:LAT];
    logic [15:0] pipe_d [1:LAT];

    dcache_ctrl #(.INDEX_BITS(6)) dut (
        .clk            (clk),
        .rst            (rst),
        .addr           (addr),
        .data_in        (data_in),
        .rd             (rd),
        .wr             (wr),
        .data_out       (data_out),
        .stall          (stall),
        .mem_addr       (mem_addr),
        .mem_data_out   (mem_data_out),
        .mem_enable     (mem_enable),
        .mem_wr         (mem_wr),
        .mem_data_in    (mem_data_in),
        .mem_data_valid (mem_data_valid),
        .miss_cnt       (miss_cnt)
    );

    always #5 clk = ~clk;

    // Main memory: sample requests mid-cycle, return read data LAT cycles later
    always @(negedge clk) begin
        mem_data_valid = pipe_v[LAT];
        mem_data_in    = pipe_d[LAT];
        for (int k = LAT; k >= 2; k--) begin
            pipe_v[k] = pipe_v[k-1];
            pipe_d[k] = pipe_d[k-1];
        end
        pipe_v[1] = mem_enable && !mem_wr;
        pipe_d[1] = mem[mem_addr[15:1]];
        if (mem_enable && mem_wr) begin
            mem[mem_addr[15:1]] = mem_data_out;
        end
    end

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue a request that is expected to miss, then check the whole fill.
    // Leaves the request held in the cycle where it completes as a hit.
    task automatic miss_txn(input logic [15:0] a, input logic w, input logic [15:0] wd,
                            input logic [15:0] exp_cnt);
        logic [15:0] base;
        base    = {a[15:4], 4'b0000};
        addr    = a;
        rd      = !w;
        wr      = w;
        data_in = wd;
        #1;
        $display("txn %s miss addr=%h", w ? "wr" : "rd", a);
        chk("miss_stall_T", {15'd0, stall}, 16'd1);
        chk("miss_noreq_T", {15'd0, mem_enable}, 16'd0);
        for (int k = 1; k <= 13; k++) begin
            step();
            if (k <= 8) begin
                chk("fill_en", {15'd0, mem_enable}, 16'd1);
                chk("fill_rd", {15'd0, mem_wr}, 16'd0);
                chk("fill_addr", mem_addr, base + 16'(2 * (k - 1)));
            end else if (k <= 12) begin
                chk("fill_idle_bus", {15'd0, mem_enable}, 16'd0);
            end
            chk("fill_stall", {15'd0, stall}, (k <= 12) ? 16'd1 : 16'd0);
        end
        chk("miss_cnt", miss_cnt, exp_cnt);
        if (w) begin
            chk("wmiss_en", {15'd0, mem_enable}, 16'd1);
            chk("wmiss_wr", {15'd0, mem_wr}, 16'd1);
            chk("wmiss_addr", mem_addr, {a[15:1], 1'b0});
            chk("wmiss_data", mem_data_out, wd);
        end
    endtask

    // Read expected to hit: same-cycle data, no stall, no memory request
    task automatic read_hit(input logic [15:0] a, input logic [15:0] exp);
        step();
        addr = a;
        rd   = 1'b1;
        wr   = 1'b0;
        #1;
        $display("txn rd hit addr=%h data=%h", a, data_out);
        chk("hit_data", data_out, exp);
        chk("hit_stall", {15'd0, stall}, 16'd0);
        chk("hit_noreq", {15'd0, mem_enable}, 16'd0);
    endtask

    initial begin
        for (int i = 0; i < 32768; i++) begin
            mem[i] = 16'(i * 2) ^ 16'h5A5A;
        end
        for (int k = 1; k <= LAT; k++) begin
            pipe_v[k] = 1'b0;
            pipe_d[k] = 16'd0;
        end
        mem_data_valid = 1'b0;
        mem_data_in    = 16'd0;
        rst     = 1'b1;
        rd      = 1'b0;
        wr      = 1'b0;
        addr    = 16'd0;
        data_in = 16'd0;
        step();
        step();
        rst = 1'b0;
        #1;
        $display("txn reset");
        chk("rst_stall", {15'd0, stall}, 16'd0);
        chk("rst_en", {15'd0, mem_enable}, 16'd0);
        chk("rst_wr", {15'd0, mem_wr}, 16'd0);
        chk("rst_addr", mem_addr, 16'd0);
        chk("rst_wdata", mem_data_out, 16'd0);
        chk("rst_dout", data_out, 16'd0);
        chk("rst_cnt", miss_cnt, 16'd0);

        // Cold read miss at 0x0042 (mem = 0x0042 ^ 0x5A5A = 0x5A18)
        step();
        miss_txn(16'h0042, 1'b0, 16'd0, 16'd1);
        chk("rd_miss_data", data_out, 16'h5A18);
        // Same line, other word: 0x004E ^ 0x5A5A = 0x5A14
        read_hit(16'h004E, 16'h5A14);
        chk("hit_cnt_same", miss_cnt, 16'd1);

        // Store hit with write-through
        step();
        addr    = 16'h0044;
        data_in = 16'hBEEF;
        rd      = 1'b0;
        wr      = 1'b1;
        #1;
        $display("txn wr hit addr=0044 data=beef");
        chk("whit_stall", {15'd0, stall}, 16'd0);
        chk("whit_en", {15'd0, mem_enable}, 16'd1);
        chk("whit_wr", {15'd0, mem_wr}, 16'd1);
        chk("whit_addr", mem_addr, 16'h0044);
        chk("whit_data", mem_data_out, 16'hBEEF);
        read_hit(16'h0044, 16'hBEEF);

        // Store miss at 0x1040: same index as 0x0040, different tag
        step();
        miss_txn(16'h1040, 1'b1, 16'h1234, 16'd2);
        read_hit(16'h1040, 16'h1234);
        // The 0x0040 line was evicted; refill sees the earlier write-through
        step();
        miss_txn(16'h0042, 1'b0, 16'd0, 16'd3);
        chk("refill_data", data_out, 16'h5A18);
        read_hit(16'h0044, 16'hBEEF);

        // Reset during a fill at T+5 while returns are still outstanding
        step();
        addr = 16'h2080;
        rd   = 1'b1;
        wr   = 1'b0;
        $display("txn rd miss addr=2080 (reset mid-fill)");
        for (int k = 1; k <= 5; k++) begin
            step();
        end
        rst = 1'b1;
        rd  = 1'b0;
        #1;
        chk("midrst_stall", {15'd0, stall}, 16'd0);
        chk("midrst_en", {15'd0, mem_enable}, 16'd0);
        step();
        rst = 1'b0;
        #1;
        chk("postrst_stall", {15'd0, stall}, 16'd0);
        chk("postrst_cnt", miss_cnt, 16'd0);
        for (int k = 0; k < 6; k++) begin
            step();
            chk("stale_stall", {15'd0, stall}, 16'd0);
            chk("stale_en", {15'd0, mem_enable}, 16'd0);
        end
        // Line must be invalid: full fill again (0x2080 ^ 0x5A5A = 0x7ADA)
        step();
        miss_txn(16'h2080, 1'b0, 16'd0, 16'd1);
        chk("afterrst_data", data_out, 16'h7ADA);

        // Counter wrap: preload near the top, then two more misses
        step();
        rd = 1'b0;
        force dut.miss_cnt_q = 16'hFFFE;
        #1;
        release dut.miss_cnt_q;
        step();
        miss_txn(16'h3000, 1'b0, 16'd0, 16'hFFFF);
        chk("wrap_data1", data_out, 16'h3000 ^ 16'h5A5A);
        step();
        miss_txn(16'h4000, 1'b0, 16'd0, 16'h0000);
        chk("wrap_data2", data_out, 16'h4000 ^ 16'h5A5A);

        step();
        rd = 1'b0;
        wr = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dcache_ctrl.md
# dcache_ctrl

Direct-mapped, write-through, write-allocate data cache with its miss-fill state machine. It sits between the CPU memory stage and the multi-cycle main data memory, replacing the single-cycle data memory. The block returns read hits combinationally in the same cycle and holds `stall` high while a 16-byte line is fetched. The fetch is 8 pipelined word reads.

## Interface
- `INDEX_BITS`, default 6: number of index bits; the cache holds 2^INDEX_BITS lines. Tag width is 12 − INDEX_BITS.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `addr`  in  16  byte address from the memory stage; `addr[0]` is ignored.
- `data_in`  in  16  store data.
- `rd`  in  1  load request.
- `wr`  in  1  store request; has priority if `rd` is also high.
- `data_out`  out  16  load data; valid only when `rd` is high and `stall` is low.
- `stall`  out  1  freezes the pipeline while a miss is serviced.
- `mem_addr`  out  16  main-memory word address (byte address, bit 0 = 0).
- `mem_data_out`  out  16  write-through data to main memory.
- `mem_enable`  out  1  main-memory request strobe.
- `mem_wr`  out  1  main-memory write; meaningful only with `mem_enable`.
- `mem_data_in`  in  16  main-memory read data.
- `mem_data_valid`  in  1  `mem_data_in` carries the next returned word of the pending fill.
- `miss_cnt`  out  16  total misses since reset; wraps at 16'hFFFF → 0.

## Operation
- Address split:
  - offset = `addr[3:1]` (8 words per line)
  - index = `addr[4+INDEX_BITS-1:4]`
  - tag = `addr[15:4+INDEX_BITS]`
- Storage: valid bits are reset to 0 by `rst`. The tag and data arrays are not reset.
- hit = valid[index] && tag match. Miss = (`rd` | `wr`) && !hit while in IDLE.
- FSM states: IDLE and FILL.
- IDLE behaviour:
  - Read hit: `data_out` = line word, same cycle; `stall` = 0.
  - Write hit: update the cached word at the clock edge. Drive `mem_enable`=1, `mem_wr`=1, `mem_addr`={addr[15:1],0}, `mem_data_out`=`data_in` in the same cycle. No stall.
  - Miss: `stall` = 1 combinationally, `miss_cnt` += 1, latch the line base {tag,index,4'b0}, go to FILL. Issue and return counters are cleared.
  - Neither `rd` nor `wr`: no memory activity; `stall` = 0.
- FILL behaviour:
  - Issue counter 0..7: while it is < 8, drive `mem_enable`=1, `mem_wr`=0, `mem_addr`=base+2·issue, then increment. One request per cycle; memory accepts every cycle.
  - Each cycle `mem_data_valid`=1: write `mem_data_in` to data[index][return counter], then increment the return counter.
  - On the 8th valid word: write the tag, set valid=1, go to IDLE.
  - `stall` = 1 throughout FILL. `data_out` = 0. No write-through is issued.
- After the fill, the held request re-evaluates in IDLE as a hit. A store miss therefore completes as a write hit (cache update plus write-through) in that cycle.
- `mem_data_valid` in IDLE is ignored. This covers stale returns after a reset.
- `rd` = `wr` = 1 is treated as a store.
- Upstream must hold `addr`, `data_in`, `rd` and `wr` stable while `stall` = 1.

## Timing
- Reset values:
  - `stall`, `mem_enable`, `mem_wr` = 0.
  - `mem_addr`, `mem_data_out`, `data_out` = 0.
  - `miss_cnt` = 0; FSM = IDLE; counters = 0; all valid bits = 0.
- Reset mid-FILL: abandon the fill. The line stays invalid, and the next cycle is IDLE with outputs at their reset values.
- Hit latency is 0 cycles, purely combinational from `addr`.
- Miss at cycle T with memory latency L (4 for our memory):
  - Requests are issued in T+1..T+8.
  - Returns arrive in T+1+L..T+8+L.
  - IDLE and the hit occur at T+9+L.
  - `stall` is high for cycles T..T+8+L, i.e. 9+L cycles (13 for L=4).
- The return counter alone gates the exit from FILL. The block works for any L ≥ 1 with in-order returns.

## Test plan
- After reset, `rd`=1, `addr`=16'h0042 → `stall` high for 13 cycles. `mem_addr` steps 16'h0040..16'h004E in cycles T+1..T+8. At T+13, `data_out` = mem[0x0042], `stall`=0, `miss_cnt`=1.
- Same line, `rd` at `addr`=16'h004E the next cycle → same-cycle hit with `stall`=0 and no `mem_enable`; `miss_cnt` stays 1.
- Store hit: `wr`=1, `addr`=16'h0044, `data_in`=16'hBEEF → `mem_enable`=`mem_wr`=1, `mem_addr`=16'h0044, `mem_data_out`=16'hBEEF. A following read of 0x0044 returns 16'hBEEF.
- Store miss at 16'h1040 (index 4, new tag; conflicts with line 0x0040) → 8 fill reads, then one write-through cycle. A subsequent read of 0x0042 misses again, and `miss_cnt` increments on each miss.
- Assert `rst` at T+5 of a fill while returns are still arriving → FSM returns to IDLE. Late `mem_data_valid` pulses are ignored. The next read of the same address misses and starts a full 13-cycle fill.
- Preload `miss_cnt` to 16'hFFFF via misses, then miss once more → `miss_cnt` wraps to 16'h0000.
